// File: rtl/box_pkg.sv
// box_pkg
// Shared types and constants for the box motion engine.
//   move_t   : per-axis move request (negative, positive, stop)
//   mode_t   : manual (clamp) or autonomous bounce
//   state_t  : update sequencer states
//   colour_t : one 4-bit colour channel
//   rgb_t    : packed colour triple, plus the colour the box starts with
//   decode_move : maps the 2-bit keyboard move code onto move_t
package box_pkg;

    typedef enum logic [1:0] {
        MOVE_NEG  = 2'd0,
        MOVE_POS  = 2'd1,
        MOVE_STOP = 2'd2
    } move_t;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef logic [3:0] colour_t;

    typedef struct packed {
        colour_t r;
        colour_t g;
        colour_t b;
    } rgb_t;

    localparam rgb_t RESET_COLOUR = '{r: 4'hF, g: 4'h0, b: 4'h0};

    // Codes 2 and 3 both mean stop, so only bit 1 is needed to detect them.
    function automatic move_t decode_move(input logic [1:0] code);
        if (code[1]) begin
            return MOVE_STOP;
        end
        return code[0] ? MOVE_POS : MOVE_NEG;
    endfunction

endpackage

// File: rtl/box_axis_stepper.sv
// box_axis_stepper
// Purely combinational single-axis position stepper.
//   pos      in  POS_W : current position of the box on this axis
//   dir      in  move_t: requested movement direction (or stop)
//   step     in  POS_W : pixels to move this frame (already saturated)
//   limit    in  POS_W : largest legal position on this axis
//   next_pos out POS_W : position after the step, clamped into [0, limit]
//   axis_hit out 1     : the step ran into an edge (and actually moved)
//   next_dir out move_t: direction reversed on a hit, otherwise unchanged
module box_axis_stepper
    import box_pkg::*;
#(
    parameter int POS_W = 10
) (
    input  logic [POS_W-1:0] pos,
    input  move_t            dir,
    input  logic [POS_W-1:0] step,
    input  logic [POS_W-1:0] limit,
    output logic [POS_W-1:0] next_pos,
    output logic             axis_hit,
    output move_t            next_dir
);

    // One extra bit so pos+step can never wrap before the clamp compare.
    logic [POS_W:0] pos_ext;
    logic [POS_W:0] step_ext;
    logic [POS_W:0] limit_ext;
    logic [POS_W:0] sum_ext;
    logic [POS_W:0] diff_ext;

    assign pos_ext   = {1'b0, pos};
    assign step_ext  = {1'b0, step};
    assign limit_ext = {1'b0, limit};
    assign sum_ext   = pos_ext + step_ext;
    assign diff_ext  = pos_ext - step_ext;

    always_comb begin
        next_pos = pos;
        case (dir)
            MOVE_NEG: begin
                if (pos_ext < step_ext) begin
                    next_pos = '0;
                end else begin
                    next_pos = diff_ext[POS_W-1:0];
                end
            end
            MOVE_POS: begin
                if (sum_ext >= limit_ext) begin
                    next_pos = limit;
                end else begin
                    next_pos = sum_ext[POS_W-1:0];
                end
            end
            default: next_pos = pos;
        endcase
    end

    // Resting against an edge while still pushing into it is not a collision.
    assign axis_hit = ((next_pos == '0) || (next_pos == limit)) && (next_pos != pos);

    always_comb begin
        next_dir = dir;
        if (axis_hit) begin
            next_dir = (dir == MOVE_POS) ? MOVE_NEG : MOVE_POS;
        end
    end

endmodule

// File: rtl/box_motion_unit.sv
// box_motion_unit
// Frame-rate motion engine for the on-screen box. One position update runs
// per rising edge of vsync: IDLE latches the controls, CALC evaluates both
// axes, COMMIT applies the new position, colour and collision count.
//   clk, rst_n            : system clock, synchronous active-low reset
//   vsync                 : frame sync (same clock domain)
//   mode                  : 0 = manual clamp, 1 = bounce
//   move_x, move_y        : 0 = negative, 1 = positive, 2/3 = stop (manual only)
//   speed                 : pixels per frame, saturated to STEP_MAX
//   box_x, box_y          : top-left corner of the box
//   box_size              : constant BOX_SIZE
//   red, green, blue      : box colour, rotated on every collision
//   hit                   : one-cycle pulse when a collision is committed
//   hit_count             : wrapping collision counter
//   busy                  : high while an update is in flight
module box_motion_unit
    import box_pkg::*;
#(
    parameter int RES_WIDTH  = 640,
    parameter int RES_HEIGHT = 480,
    parameter int BOX_SIZE   = 40,
    parameter int POS_W      = 10,
    parameter int STEP_MAX   = 8,
    parameter int SPEED_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               mode,
    input  logic [1:0]         move_x,
    input  logic [1:0]         move_y,
    input  logic [SPEED_W-1:0] speed,
    output logic [POS_W-1:0]   box_x,
    output logic [POS_W-1:0]   box_y,
    output logic [POS_W-1:0]   box_size,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hit,
    output logic [7:0]         hit_count,
    output logic               busy
);

    localparam logic [POS_W-1:0] X_MAX      = POS_W'(RES_WIDTH - BOX_SIZE);
    localparam logic [POS_W-1:0] Y_MAX      = POS_W'(RES_HEIGHT - BOX_SIZE);
    localparam logic [POS_W-1:0] STEP_LIMIT = POS_W'(STEP_MAX);

    // ------------------------------------------------------------------
    // Frame tick: first cycle of vsync high
    // ------------------------------------------------------------------
    logic vsync_d_reg;
    logic tick;

    assign tick = vsync & ~vsync_d_reg;

    // ------------------------------------------------------------------
    // Shared control state
    // ------------------------------------------------------------------
    state_t           state_reg;
    mode_t            mode_lat_reg;
    logic [POS_W-1:0] step_reg;
    logic             busy_reg;
    logic             hit_reg;
    logic [7:0]       hit_count_reg;
    rgb_t             colour_reg;

    logic [31:0]      speed_wide;
    logic [POS_W-1:0] step_sat;

    logic [1:0][1:0]       move_code;
    logic [1:0][POS_W-1:0] pos_vec;
    logic [1:0]            axis_hit_vec;

    assign move_code = {move_y, move_x};

    // Compare at 32 bits so STEP_MAX may be wider or narrower than speed.
    assign speed_wide = 32'(speed);
    assign step_sat   = (speed_wide > 32'(STEP_MAX)) ? STEP_LIMIT : speed_wide[POS_W-1:0];

    // ------------------------------------------------------------------
    // Per-axis datapath: index 0 is x, index 1 is y
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic [POS_W-1:0] LIMIT     = (gi == 0) ? X_MAX : Y_MAX;
            localparam logic [POS_W-1:0] RESET_POS = LIMIT >> 1;

            logic [POS_W-1:0] pos_reg;
            logic [POS_W-1:0] next_pos_reg;
            logic             axis_hit_reg;
            logic             dir_reg;       // 1 = positive (right/down)
            logic             next_dir_reg;
            move_t            move_lat_reg;

            move_t            move_eff;
            logic [POS_W-1:0] step_next_pos;
            logic             step_hit;
            move_t            step_next_dir;

            // Bounce mode ignores the keyboard and follows the direction register.
            always_comb begin
                move_eff = move_lat_reg;
                if (mode_lat_reg == MODE_BOUNCE) begin
                    move_eff = dir_reg ? MOVE_POS : MOVE_NEG;
                end
            end

            box_axis_stepper #(
                .POS_W(POS_W)
            ) u_stepper (
                .pos      (pos_reg),
                .dir      (move_eff),
                .step     (step_reg),
                .limit    (LIMIT),
                .next_pos (step_next_pos),
                .axis_hit (step_hit),
                .next_dir (step_next_dir)
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pos_reg      <= RESET_POS;
                    next_pos_reg <= RESET_POS;
                    axis_hit_reg <= 1'b0;
                    dir_reg      <= 1'b1;
                    next_dir_reg <= 1'b1;
                    move_lat_reg <= MOVE_STOP;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (tick) begin
                                move_lat_reg <= decode_move(move_code[gi]);
                            end
                        end
                        CALC: begin
                            next_pos_reg <= step_next_pos;
                            axis_hit_reg <= step_hit;
                            next_dir_reg <= (step_next_dir == MOVE_POS);
                        end
                        COMMIT: begin
                            pos_reg <= next_pos_reg;
                            // Manual mode leaves the bounce heading untouched.
                            if (mode_lat_reg == MODE_BOUNCE) begin
                                dir_reg <= next_dir_reg;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign pos_vec[gi]      = pos_reg;
            assign axis_hit_vec[gi] = axis_hit_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer, colour and collision counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d_reg   <= 1'b0;
            state_reg     <= IDLE;
            mode_lat_reg  <= MODE_MANUAL;
            step_reg      <= '0;
            busy_reg      <= 1'b0;
            hit_reg       <= 1'b0;
            hit_count_reg <= 8'd0;
            colour_reg    <= RESET_COLOUR;
        end else begin
            vsync_d_reg <= vsync;
            hit_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        mode_lat_reg <= mode ? MODE_BOUNCE : MODE_MANUAL;
                        step_reg     <= step_sat;
                        busy_reg     <= 1'b1;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    state_reg <= COMMIT;
                end
                COMMIT: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                    // A corner hit is still a single collision.
                    if (|axis_hit_vec) begin
                        hit_reg       <= 1'b1;
                        hit_count_reg <= hit_count_reg + 8'd1;
                        colour_reg    <= '{r: colour_reg.g, g: colour_reg.b, b: colour_reg.r};
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign box_x     = pos_vec[0];
    assign box_y     = pos_vec[1];
    assign box_size  = POS_W'(BOX_SIZE);
    assign red       = colour_reg.r;
    assign green     = colour_reg.g;
    assign blue      = colour_reg.b;
    assign hit       = hit_reg;
    assign hit_count = hit_count_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_box_motion_unit.sv
module tb_box_motion_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       mode;
    logic [1:0] move_x;
    logic [1:0] move_y;
    logic [3:0] speed;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [9:0] box_size;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hit;
    logic [7:0] hit_count;
    logic       busy;

    box_motion_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .mode      (mode),
        .move_x    (move_x),
        .move_y    (move_y),
        .speed     (speed),
        .box_x     (box_x),
        .box_y     (box_y),
        .box_size  (box_size),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hit       (hit),
        .hit_count (hit_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: whole-frame behaviour with plain integer arithmetic
    // ------------------------------------------------------------------
    typedef struct {
        int x;
        int y;
        int r;
        int g;
        int b;
        int hit;
        int cnt;
        int cyc;
    } exp_t;

    exp_t q[$];

    int mx, my, mr, mg, mb, mcnt, mdx, mdy, mhits;
    localparam int XMAX = 600;
    localparam int YMAX = 440;

    task automatic model_reset();
        mx = 300; my = 220; mr = 15; mg = 0; mb = 0; mcnt = 0; mdx = 1; mdy = 1;
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int code_dir(input logic [1:0] c);
        if (c == 2'd0) return -1;
        if (c == 2'd1) return 1;
        return 0;
    endfunction

    // Applies one frame to the model and returns the expected outputs.
    task automatic model_frame(input bit md, input logic [1:0] ax, input logic [1:0] ay,
                               input int sp, output exp_t e);
        int s, dx, dy, nx, ny, t;
        bit hx, hy;
        s  = (sp > 8) ? 8 : sp;
        dx = md ? mdx : code_dir(ax);
        dy = md ? mdy : code_dir(ay);
        nx = clamp(mx + dx * s, XMAX);
        ny = clamp(my + dy * s, YMAX);
        hx = ((nx == 0) || (nx == XMAX)) && (nx != mx);
        hy = ((ny == 0) || (ny == YMAX)) && (ny != my);
        if (md && hx) mdx = -mdx;
        if (md && hy) mdy = -mdy;
        mx = nx;
        my = ny;
        if (hx || hy) begin
            t = mr; mr = mg; mg = mb; mb = t;
            mcnt = (mcnt + 1) % 256;
            mhits++;
        end
        e.x = mx; e.y = my; e.r = mr; e.g = mg; e.b = mb;
        e.hit = (hx || hy) ? 1 : 0;
        e.cnt = mcnt;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic frame(input bit md, input logic [1:0] ax, input logic [1:0] ay, input int sp);
        exp_t e;
        @(negedge clk);
        mode = md; move_x = ax; move_y = ay; speed = 4'(sp); vsync = 1'b1;
        model_frame(md, ax, ay, sp, e);
        // tick edge is cyc+1; commit lands two edges later
        e.cyc = cyc + 3;
        q.push_back(e);
        @(negedge clk);
        vsync = 1'b0;
        // Scramble the controls mid-update; they must be ignored.
        mode   = 1'($urandom);
        move_x = 2'($urandom);
        move_y = 2'($urandom);
        speed  = 4'($urandom);
        repeat (3) @(negedge clk);
        $display("frame md=%0d mx=%0d my=%0d sp=%0d -> exp (%0d,%0d) hit=%0d cnt=%0d",
                 md, ax, ay, sp, e.x, e.y, e.hit, e.cnt);
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int d;
        while (mx != tx) begin
            d = (tx > mx) ? tx - mx : mx - tx;
            frame(1'b0, (tx > mx) ? 2'd1 : 2'd0, 2'd2, (d > 8) ? 8 : d);
        end
        while (my != ty) begin
            d = (ty > my) ? ty - my : my - ty;
            frame(1'b0, 2'd2, (ty > my) ? 2'd1 : 2'd0, (d > 8) ? 8 : d);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, box_x, 300);
        chk({tag, "_y"}, box_y, 220);
        chk({tag, "_red"}, red, 15);
        chk({tag, "_green"}, green, 0);
        chk({tag, "_blue"}, blue, 0);
        chk({tag, "_count"}, hit_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hit"}, hit, 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: an update finishes when busy falls
    // ------------------------------------------------------------------
    int  hit_cycles = 0;
    bit  prev_busy  = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                if (hit) hit_cycles++;
                if (prev_busy && !busy) begin
                    if (q.size() == 0) begin
                        chk("unexpected_commit", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("commit_cycle", cyc, e.cyc);
                        chk("box_x", box_x, e.x);
                        chk("box_y", box_y, e.y);
                        chk("red", red, e.r);
                        chk("green", green, e.g);
                        chk("blue", blue, e.b);
                        chk("hit", hit, e.hit);
                        chk("hit_count", hit_count, e.cnt);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; vsync = 1'b0; mode = 1'b0; move_x = 2'd2; move_y = 2'd2; speed = 4'd0;
        mhits = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        chk("box_size", box_size, 40);
        $display("reset checked");

        // Manual right by 4
        frame(1'b0, 2'd1, 2'd2, 4);

        // Approach the right edge, then clamp with a hit, then push again
        goto_xy(598, 220);
        frame(1'b0, 2'd1, 2'd2, 4);
        frame(1'b0, 2'd1, 2'd2, 4);

        // Bounce off the right edge; move codes point the other way
        goto_xy(598, 220);
        frame(1'b1, 2'd0, 2'd0, 4);
        frame(1'b1, 2'd0, 2'd0, 4);

        // Corner hit counts once, then speed saturation
        goto_xy(2, 1);
        frame(1'b0, 2'd0, 2'd0, 3);
        frame(1'b0, 2'd1, 2'd1, 12);

        // Reset asserted while the update sits in CALC
        @(negedge clk);
        mode = 1'b0; move_x = 2'd1; move_y = 2'd1; speed = 4'd8; vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("rst_calc");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset during CALC checked");
        frame(1'b0, 2'd0, 2'd1, 5);

        // Randomized frames
        for (int i = 0; i < 300; i++) begin
            frame(1'($urandom), 2'($urandom), 2'($urandom), int'($urandom_range(0, 15)));
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("hit_pulses", hit_cycles, mhits);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
